// File: rtl/ika_slotgen_pkg.sv
// ==========================================================================
// ika_slotgen_pkg : shared defaults, sample-hold patterns, slot-width helper
// Revision 1.0
// ==========================================================================
`default_nettype none

package ika_slotgen_pkg;

  localparam int SLOTS_DEF   = 32;
  localparam int PHI_DIV_DEF = 2;
  localparam int NTAP_DEF    = 8;
  localparam int SH_DLY_DEF  = 5;
  localparam int FW_DEF      = 8;

  localparam logic [1:0] SH1_PAT = 2'b11;
  localparam logic [1:0] SH2_PAT = 2'b01;

  function automatic int cw_from_slots(input int slots);
    return $clog2(slots);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ika_slotgen_tap.sv
// ==========================================================================
// ika_slotgen_tap : one masked slot comparator with a tick-enabled register
// Revision 1.0
// ==========================================================================
`default_nettype none

module ika_slotgen_tap
  import ika_slotgen_pkg::*;
#(
  parameter int CW = cw_from_slots(SLOTS_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_tick,
  input  logic          i_en,
  input  logic [CW-1:0] i_cnt,
  input  logic [CW-1:0] i_slot,
  input  logic [CW-1:0] i_mask,
  output logic          o_tap
);

  logic tap_d;
  logic tap_q;

  always_comb begin
    tap_d = tap_q;
    if (i_tick) begin
      tap_d = i_en & (((i_cnt ^ i_slot) & i_mask) == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q <= 1'b0;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign o_tap = tap_q;

endmodule

`default_nettype wire

// File: rtl/ika_slotgen.sv
// ==========================================================================
// ika_slotgen : phi1 generator, IC sync, slot counter, taps, SH strobes, frame
// Revision 1.0
// ==========================================================================
`default_nettype none

module ika_slotgen
  import ika_slotgen_pkg::*;
#(
  parameter int SLOTS   = SLOTS_DEF,
  parameter int PHI_DIV = PHI_DIV_DEF,
  parameter int NTAP    = NTAP_DEF,
  parameter int SH_DLY  = SH_DLY_DEF,
  parameter int FW      = FW_DEF
) (
  input  logic                                i_EMUCLK,
  input  logic                                i_RST,
  input  logic                                i_phiM_PCEN_n,
  input  logic                                i_IC_n,
  input  logic [NTAP*cw_from_slots(SLOTS)-1:0] i_TAP_SLOT,
  input  logic [NTAP*cw_from_slots(SLOTS)-1:0] i_TAP_MASK,
  output logic                                o_MRST_n,
  output logic                                o_phi1,
  output logic                                o_phi1_PCEN_n,
  output logic                                o_phi1_NCEN_n,
  output logic [cw_from_slots(SLOTS)-1:0]     o_SLOT,
  output logic [NTAP-1:0]                     o_TAP,
  output logic                                o_SH1,
  output logic                                o_SH2,
  output logic [FW-1:0]                       o_FRAME,
  output logic                                o_WRAP
);

  localparam int CW   = cw_from_slots(SLOTS);
  localparam int PW   = $clog2(PHI_DIV);
  localparam int HALF = PHI_DIV / 2;

  logic              pcen;
  logic              tick;
  logic              mrst_next;
  logic [1:0]        ic_sync_d, ic_sync_q;
  logic              init_d, init_q;
  logic [PW-1:0]     ph_d, ph_q;
  logic              mrst_n_d, mrst_n_q;
  logic [CW-1:0]     cnt_d, cnt_q;
  logic [CW-1:0]     slot_d, slot_q;
  logic [SH_DLY-1:0] sr1_d, sr1_q;
  logic [SH_DLY-1:0] sr2_d, sr2_q;
  logic              sh1_d, sh1_q;
  logic              sh2_d, sh2_q;
  logic [FW-1:0]     frame_d, frame_q;
  logic              wrap_d, wrap_q;

  assign pcen = ~i_phiM_PCEN_n & ~i_RST;

  assign o_phi1        = (ph_q < PW'(HALF));
  assign o_phi1_NCEN_n = ~(pcen & (ph_q == PW'(HALF - 1)) & ~init_q);
  assign o_phi1_PCEN_n = ~(pcen & (ph_q == PW'(PHI_DIV - 1)));
  assign tick          = ~o_phi1_NCEN_n;

  // Value o_MRST_n is about to take; gating with it keeps taps, wrap, frame
  // and SH strobes quiet from the very tick the core reset asserts.
  assign mrst_next = ic_sync_q[0];

  always_comb begin
    ic_sync_d = ic_sync_q;
    init_d    = init_q;
    ph_d      = ph_q;
    mrst_n_d  = mrst_n_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    sr1_d     = sr1_q;
    sr2_d     = sr2_q;
    sh1_d     = sh1_q;
    sh2_d     = sh2_q;
    frame_d   = frame_q;
    wrap_d    = wrap_q;

    if (pcen) begin
      ic_sync_d = {ic_sync_q[0], i_IC_n};
      init_d    = ~ic_sync_q[0] & ic_sync_q[1];
      if (init_q || (ph_q == PW'(PHI_DIV - 1))) begin
        ph_d = '0;
      end else begin
        ph_d = ph_q + PW'(1);
      end
    end

    if (tick) begin
      mrst_n_d = mrst_next;
      cnt_d    = (mrst_n_q & mrst_next) ? cnt_q + CW'(1) : '0;
      slot_d   = cnt_q;
      sr1_d    = SH_DLY'({sr1_q, (cnt_q[CW-1 -: 2] == SH1_PAT)});
      sr2_d    = SH_DLY'({sr2_q, (cnt_q[CW-1 -: 2] == SH2_PAT)});
      sh1_d    = sr1_q[SH_DLY-1] & mrst_next;
      sh2_d    = sr2_q[SH_DLY-1] & mrst_next;
      wrap_d   = mrst_next & (cnt_q == CW'(SLOTS - 1));
      if (!mrst_next) begin
        frame_d = '0;
      end else if (cnt_q == CW'(SLOTS - 1)) begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      ic_sync_q <= 2'b00;
      init_q    <= 1'b1;
      ph_q      <= '0;
      mrst_n_q  <= 1'b0;
      cnt_q     <= '0;
      slot_q    <= '0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      sh1_q     <= 1'b0;
      sh2_q     <= 1'b0;
      frame_q   <= '0;
      wrap_q    <= 1'b0;
    end else begin
      ic_sync_q <= ic_sync_d;
      init_q    <= init_d;
      ph_q      <= ph_d;
      mrst_n_q  <= mrst_n_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      sr1_q     <= sr1_d;
      sr2_q     <= sr2_d;
      sh1_q     <= sh1_d;
      sh2_q     <= sh2_d;
      frame_q   <= frame_d;
      wrap_q    <= wrap_d;
    end
  end

  generate
    for (genvar i = 0; i < NTAP; i++) begin : g_tap
      ika_slotgen_tap #(
        .CW (CW)
      ) u_tap (
        .clk    (i_EMUCLK),
        .rst    (i_RST),
        .i_tick (tick),
        .i_en   (mrst_next),
        .i_cnt  (cnt_q),
        .i_slot (i_TAP_SLOT[i*CW +: CW]),
        .i_mask (i_TAP_MASK[i*CW +: CW]),
        .o_tap  (o_TAP[i])
      );
    end
  endgenerate

  assign o_MRST_n = mrst_n_q;
  assign o_SLOT   = slot_q;
  assign o_SH1    = sh1_q;
  assign o_SH2    = sh2_q;
  assign o_FRAME  = frame_q;
  assign o_WRAP   = wrap_q;

endmodule

`default_nettype wire

// File: doc/ika_slotgen.md
IKA_SLOTGEN -- requirements
Module: ika_slotgen

Interface
REQ-001 Parameter SLOTS, default 32, slots per sample frame; power of two, 8..64; CW = log2(SLOTS).
REQ-002 Parameter PHI_DIV, default 2, phiM enables per phi1 period; even, 2..8.
REQ-003 Parameter NTAP, default 8, number of programmable slot-decode outputs, 1..16.
REQ-004 Parameter SH_DLY, default 5, SH1/SH2 delay in phi1 ticks, 1..8.
REQ-005 Parameter FW, default 8, width of the frame counter.
REQ-006 i_EMUCLK  in  1  emulator master clock; single clock domain.
REQ-007 i_RST  in  1  synchronous, active-high reset.
REQ-008 i_phiM_PCEN_n  in  1  phiM clock enable, active low, one i_EMUCLK wide.
REQ-009 i_IC_n  in  1  chip initial-clear, active low, asynchronous to phiM.
REQ-010 i_TAP_SLOT  in  NTAP*CW  per-tap slot compare value; tap i at bits [i*CW +: CW].
REQ-011 i_TAP_MASK  in  NTAP*CW  per-tap compare mask; 1 = bit compared, 0 = don't-care.
REQ-012 o_MRST_n  out  1  core internal reset, active low.
REQ-013 o_phi1 / o_phi1_PCEN_n / o_phi1_NCEN_n  out  1 each  phi1 level, rising and falling enables, active low.
REQ-014 o_SLOT  out  CW  registered slot number.
REQ-015 o_TAP  out  NTAP  registered per-tap decode pulses.
REQ-016 o_SH1, o_SH2  out  1 each  delayed sample-hold strobes.
REQ-017 o_FRAME  out  FW  frame counter; o_WRAP  out  1  one-tick pulse at frame wrap.

Function
REQ-018 i_IC_n is sampled by a 2-stage shift register on each phiM enable; init = stage0 low AND stage1 high, registered on the phiM enable.
REQ-019 Phase counter ph (0..PHI_DIV-1) advances on each phiM enable and wraps to 0; while init is 1 it loads 0.
REQ-020 o_phi1 = 1 when ph < PHI_DIV/2, else 0.
REQ-021 o_phi1_NCEN_n is low only in the phiM-enable cycle with ph == PHI_DIV/2-1 and init == 0.
REQ-022 o_phi1_PCEN_n is low only in the phiM-enable cycle with ph == PHI_DIV-1.
REQ-023 All items below update only on the phi1 falling enable ("tick").
REQ-024 o_MRST_n takes IC sync stage0 on each tick.
REQ-025 Slot counter: loads 0 while o_MRST_n == 0; otherwise increments modulo SLOTS; o_SLOT = counter registered once.
REQ-026 o_TAP[i] = 1 on the tick after counter value c where ((c XOR slot_i) AND mask_i) == 0; mask 0 asserts the tap every tick.
REQ-027 sh1 raw = counter top two bits == 2'b11; sh2 raw = 2'b01; each is delayed SH_DLY ticks by a shift register, then ANDed with o_MRST_n into o_SH1/o_SH2.
REQ-028 o_WRAP = 1 on the tick after counter == SLOTS-1; o_FRAME increments on that same tick and wraps from 2^FW-1 to 0.
REQ-029 While o_MRST_n == 0: o_FRAME holds 0; o_WRAP and o_TAP are 0.
REQ-030 An i_IC_n assertion mid-frame forces counter 0 on the first tick after sync; no partial-frame o_WRAP is produced.
REQ-031 Tap inputs may change at any time; they take effect on the next tick.

Reset
REQ-032 While i_RST == 1 on an i_EMUCLK edge: IC sync = 2'b00, init = 1, ph = 0, o_MRST_n = 0, counter and shift registers = 0, and all registered outputs = 0; o_phi1 = 1.
REQ-033 i_RST overrides every enable.
REQ-034 After reset release, o_MRST_n rises only after i_IC_n is high through sync and one tick.

Structure
REQ-035 A shared package holds the parameter defaults, the SH pattern constants 2'b11/2'b01, and a CW-from-SLOTS function.
REQ-036 Tap decode is a sub-module, ika_slotgen_tap, instantiated NTAP times; each instance is one comparator plus one register.

Verification
REQ-037 Defaults, phiM enable every 4th EMUCLK, release IC -> o_MRST_n high; o_SLOT steps 0..31; o_WRAP fires once per 32 ticks.
REQ-038 PHI_DIV = 4 -> phi1 high 2 phiM enables and low 2; exactly 1 NCEN and 1 PCEN per 4 phiM enables.
REQ-039 Tap0 slot = 5, mask = 5'h1F; tap1 slot = 3, mask = 5'h07 -> tap0 pulses once per frame; tap1 pulses at slots 3/11/19/27, each on the tick after the match.
REQ-040 SH_DLY = 5 -> o_SH1 high for 8 ticks, starting 6 ticks after counter first reads 24; o_SH2 likewise after counter reads 8.
REQ-041 Pulse i_IC_n low at slot 17 -> counter 0 after sync; o_FRAME holds 0 and no o_WRAP until a full 32-tick frame completes.
REQ-042 FW = 2, run 5 frames -> o_FRAME reads 1, 2, 3, 0, 1; i_RST mid-frame -> all outputs 0 on the next EMUCLK.
